// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device command transmitter:
// FSM state encoding, common keyboard command bytes and microsecond-to-cycle conversion.
`timescale 1ns/1ps
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE      = 3'd0;
  localparam ps2_state_t ST_INHIBIT   = 3'd1;
  localparam ps2_state_t ST_REQUEST   = 3'd2;
  localparam ps2_state_t ST_DATA      = 3'd3;
  localparam ps2_state_t ST_PARITY    = 3'd4;
  localparam ps2_state_t ST_STOP      = 3'd5;
  localparam ps2_state_t ST_ACK       = 3'd6;
  localparam ps2_state_t ST_WAIT_IDLE = 3'd7;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    logic [63:0] prod;
    prod = 64'(clk_hz) * 64'(us);
    return 32'(prod / 64'd1000000);
  endfunction

endpackage

// File: rtl/ps2_command_tx_line_sync.sv
// Two-flop synchronizer plus falling-edge detector for one raw PS/2 pin.
`timescale 1ns/1ps
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Idle-high reset values keep a spurious fall from appearing right after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ACK.
// Optional watchdog on the device clocking is built when PS2_TX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY  = 25000000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       send_command,
  input  logic [7:0] command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INHIBIT_RAW = us_to_cycles(CLOCK_FREQUENCY, INHIBIT_US);
  localparam int unsigned START_RAW   = us_to_cycles(CLOCK_FREQUENCY, START_TIMEOUT_US);
  localparam int unsigned XFER_RAW    = us_to_cycles(CLOCK_FREQUENCY, XFER_TIMEOUT_US);
  localparam int unsigned INHIBIT_CYC = (INHIBIT_RAW == 0) ? 1 : INHIBIT_RAW;
  localparam int unsigned START_CYC   = (START_RAW == 0) ? 1 : START_RAW;
  localparam int unsigned XFER_CYC    = (XFER_RAW == 0) ? 1 : XFER_RAW;
  localparam int unsigned TO_MAX      = (START_CYC > XFER_CYC) ? START_CYC : XFER_CYC;
  localparam int unsigned MAX_CYC     = (TO_MAX > INHIBIT_CYC) ? TO_MAX : INHIBIT_CYC;
  localparam int          TIMER_W     = $clog2(MAX_CYC) + 1;
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYC - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_CYC - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST  = TIMER_W'(XFER_CYC - 1);
`endif

  logic clk_level, clk_fall, dat_level;
  logic dat_fall_unused;  // the data line only needs its synchronized level

  ps2_line_sync u_clk_sync (
    .clk_i  (Clock),
    .rst_ni (reset),
    .line_i (ps2_clk_in),
    .level_o(clk_level),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk_i  (Clock),
    .rst_ni (reset),
    .line_i (ps2_dat_in),
    .level_o(dat_level),
    .fall_o (dat_fall_unused)
  );

  ps2_state_t           state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 dat_oe_q, dat_oe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
`ifdef PS2_TX_TIMEOUT_EN
  logic                 xfer_active, start_phase;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (send_command) begin
          shift_d  = command;
          parity_d = ~^command;
          cnt_d    = '0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (timer_q == INHIBIT_LAST) begin
          dat_oe_d = 1'b1;
          state_d  = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        clk_oe_d = 1'b0;
        timer_d  = '0;
        state_d  = ST_DATA;
      end
      ST_DATA: begin
        // LSB first: the shifter always presents the next bit at position 0
        if (clk_fall) begin
          cnt_d    = cnt_q + 4'd1;
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          if (cnt_q == 4'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          cnt_d    = cnt_q + 4'd1;
          dat_oe_d = ~parity_q;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          cnt_d    = cnt_q + 4'd1;
          dat_oe_d = 1'b0;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          cnt_d = cnt_q + 4'd1;
          if (!dat_level) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_level && dat_level) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Start window runs until the first fall; the transfer window restarts there.
    xfer_active = (state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP) ||
                  (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    start_phase = (state_q == ST_DATA) && (cnt_q == 4'd0);
    if (xfer_active) begin
      timer_d = (start_phase && clk_fall) ? '0 : timer_q + TIMER_W'(1);
      if (start_phase ? (timer_q == START_LAST) : (timer_q == XFER_LAST)) begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b1;
        state_d  = ST_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      timer_q  <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx with a 12.5 kHz PS/2 device model and a frame scoreboard.
`timescale 1ns/1ps
module tb_ps2_command_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ   = 2000000;
  localparam time         HALF_SYS = 250;
  localparam time         DEV_HALF = 40000;

  logic       Clock = 1'b0;
  logic       reset = 1'b0;
  logic       send_command = 1'b0;
  logic [7:0] command = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

  // Open-drain wire: low if either side pulls it down
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_command_tx #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .INHIBIT_US      (120),
    .START_TIMEOUT_US(20),
    .XFER_TIMEOUT_US (2000)
  ) dut (
    .Clock       (Clock),
    .reset       (reset),
    .send_command(send_command),
    .command     (command),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_dat_in  (ps2_dat_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_dat_oe  (ps2_dat_oe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #HALF_SYS Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cycles = 0;
  int error_cycles = 0;
  int pulse_viol = 0;

  always @(negedge Clock) begin
    if (done)  done_cycles  <= done_cycles + 1;
    if (error) error_cycles <= error_cycles + 1;
    if ((done && error) || ((done || error) && busy)) pulse_viol <= pulse_viol + 1;
  end

  logic [10:0] exp_frames[$];
  bit          exp_ok[$];

`define CHK(TAG, OBS, EXP) \
  begin \
    n_checks++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
    end \
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send(input logic [7:0] cmd, input bit expect_ok, input bit push);
    logic par;
    @(negedge Clock);
    command      = cmd;
    send_command = 1'b1;
    @(negedge Clock);
    send_command = 1'b0;
    command      = ~cmd;
    if (push) begin
      par = ($countones(cmd) % 2 == 0) ? 1'b1 : 1'b0;
      exp_frames.push_back({1'b1, par, cmd, 1'b0});
      exp_ok.push_back(expect_ok);
    end
  endtask

  // Device side: waits for request-to-send, clocks 11 bits, samples data on rising edges
  task automatic dev_xfer(input bit ack, input int abort_fall,
                          output logic [10:0] frame, output bit ok);
    int n = 0;
    frame = '0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    `CHK("rts_seen", (n < 2000), 1'b1)
    ok = (n < 2000);
    if (!ok) return;
    frame[0] = ps2_dat_in;
    #10000;
    for (int f = 1; f <= 11; f++) begin
      if (f == 11) begin
        dev_dat_low = ack;
        #20000;
      end
      dev_clk_low = 1'b1;
      if (f == abort_fall) begin
        #2000;
        reset = 1'b0;
        #1;
        `CHK("rst_clk_oe", ps2_clk_oe, 1'b0)
        `CHK("rst_dat_oe", ps2_dat_oe, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        dev_clk_low = 1'b0;
        #5000;
        @(negedge Clock);
        reset = 1'b1;
        ok = 1'b0;
        return;
      end
      #DEV_HALF;
      dev_clk_low = 1'b0;
      if (f <= 10) frame[f] = ps2_dat_in;
      #DEV_HALF;
      if (f == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic transfer(input bit ack, input string tag, output logic [10:0] frame);
    int d0 = done_cycles;
    int e0 = error_cycles;
    int n  = 0;
    bit ok;
    logic [10:0] exp_f;
    bit exp_o;
    dev_xfer(ack, 0, frame, ok);
    exp_f = exp_frames.pop_front();
    exp_o = exp_ok.pop_front();
    if (ok) `CHK({tag, "_frame"}, frame, exp_f)
    while (busy && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    `CHK({tag, "_busy_low"}, busy, 1'b0)
    tick(2);
    `CHK({tag, "_done_cycles"}, done_cycles - d0, (exp_o ? 1 : 0))
    `CHK({tag, "_error_cycles"}, error_cycles - e0, (exp_o ? 0 : 1))
    `CHK({tag, "_clk_oe_idle"}, ps2_clk_oe, 1'b0)
    `CHK({tag, "_dat_oe_idle"}, ps2_dat_oe, 1'b0)
    $display("xfer %s: frame=%b done=%0d error=%0d", tag, frame,
             done_cycles - d0, error_cycles - e0);
  endtask

  initial begin
    logic [10:0] fr;
    bit          ok;
    int          d0, e0, n;
    time         t0;

    reset = 1'b0;
    tick(3);
    `CHK("reset_clk_oe", ps2_clk_oe, 1'b0)
    `CHK("reset_dat_oe", ps2_dat_oe, 1'b0)
    `CHK("reset_busy", busy, 1'b0)
    `CHK("reset_done", done, 1'b0)
    `CHK("reset_error", error, 1'b0)
    reset = 1'b1;
    tick(3);

    // Happy path with set-LEDs
    send(CMD_SET_LEDS, 1'b1, 1'b1);
    `CHK("accept_clk_oe", ps2_clk_oe, 1'b1)
    `CHK("accept_busy", busy, 1'b1)
    transfer(1'b1, "set_leds", fr);
    `CHK("set_leds_wire", fr, 11'b1_1_11101101_0)

    // Parity cases
    send(8'h00, 1'b1, 1'b1);
    transfer(1'b1, "cmd_00", fr);
    `CHK("cmd_00_parity", fr[9], 1'b1)
    send(CMD_RESET, 1'b1, 1'b1);
    transfer(1'b1, "cmd_ff", fr);
    `CHK("cmd_ff_parity", fr[9], 1'b1)
    `CHK("cmd_ff_released", fr[8:1], 8'hFF)

    // Device withholds ACK
    send(8'h5A, 1'b0, 1'b1);
    transfer(1'b0, "no_ack", fr);

    // Second request while busy must be dropped
    send(CMD_ECHO, 1'b1, 1'b1);
    tick(5);
    send(CMD_RESET, 1'b1, 1'b0);
    transfer(1'b1, "ignored_req", fr);
    `CHK("ignored_req_wire", fr[8:1], CMD_ECHO)

    // Async reset at fall 5, then a clean transfer
    d0 = done_cycles;
    e0 = error_cycles;
    send(CMD_SET_LEDS, 1'b1, 1'b0);
    dev_xfer(1'b1, 5, fr, ok);
    tick(4);
    `CHK("abort_no_done", done_cycles - d0, 0)
    `CHK("abort_no_error", error_cycles - e0, 0)
    `CHK("abort_busy", busy, 1'b0)
    $display("xfer abort_at_fall5: busy=%0b clk_oe=%0b dat_oe=%0b", busy, ps2_clk_oe, ps2_dat_oe);
    send(CMD_SET_LEDS, 1'b1, 1'b1);
    transfer(1'b1, "after_reset", fr);

`ifdef PS2_TX_TIMEOUT_EN
    // Device never clocks: start watchdog fires about 20 us after the request
    e0 = error_cycles;
    send(CMD_RESET, 1'b0, 1'b0);
    n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    `CHK("timeout_rts_seen", (n < 2000), 1'b1)
    t0 = $time;
    n = 0;
    while (!error && n < 400) begin
      @(negedge Clock);
      n++;
    end
    `CHK("timeout_error_pulse", error, 1'b1)
    `CHK("timeout_window", (($time - t0) >= 18000) && (($time - t0) <= 24000), 1'b1)
    tick(2);
    `CHK("timeout_clk_oe", ps2_clk_oe, 1'b0)
    `CHK("timeout_dat_oe", ps2_dat_oe, 1'b0)
    `CHK("timeout_busy", busy, 1'b0)
    `CHK("timeout_error_cycles", error_cycles - e0, 1)
    $display("xfer start_timeout: elapsed=%0t error_cycles=%0d", $time - t0, error_cycles - e0);
`endif

    `CHK("pulse_rules", pulse_viol, 0)
    `CHK("scoreboard_empty", exp_frames.size(), 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
